// File: rtl/datapath_pkg.sv
// Shared opcode constants and the flag bundle
// for the parameterised two-stage datapath.
package datapath_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_SHL    = 4'd5;
    localparam logic [3:0] OP_SHR    = 4'd6;
    localparam logic [3:0] OP_PASS_B = 4'd7;
    localparam logic [3:0] OP_CMP    = 4'd8;

    localparam int NUM_OPS = 9;

    typedef struct packed {
        logic sign;
        logic zero;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: wrapping arithmetic, logic ops
// and shifts; flags shifts out of range and unknown opcodes.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              err
);

    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic              shift_bad;

    assign sum       = a + b;
    assign diff      = a - b;
    assign add_ovf   = (a[DATA_W-1] == b[DATA_W-1]) &&
                       (sum[DATA_W-1] != a[DATA_W-1]);
    assign sub_ovf   = (a[DATA_W-1] != b[DATA_W-1]) &&
                       (diff[DATA_W-1] != a[DATA_W-1]);
    assign shift_bad = (b >= SHIFT_LIM);

    // Opcode decode; anything not listed is an error with result 0
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                ovf    = add_ovf;
            end
            OP_SUB, OP_CMP: begin
                result = diff;
                ovf    = sub_ovf;
            end
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_SHL: begin
                if (shift_bad) err = 1'b1;
                else           result = a << b;
            end
            OP_SHR: begin
                if (shift_bad) err = 1'b1;
                else           result = a >> b;
            end
            OP_PASS_B: result = b;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/param_datapath.sv
// Register file + execute/writeback pipeline around datapath_alu.
// Define DATAPATH_FORWARD_EN to forward WB instead of stalling.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    localparam int SEL_W = $clog2(NREGS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [3:0]              alu_op,
    input  logic [SEL_W-1:0]        a_sel,
    input  logic [SEL_W-1:0]        b_sel,
    input  logic [SEL_W-1:0]        dest_sel,
    input  logic                    a_src,
    input  logic                    b_src,
    input  logic [DATA_W-1:0]       a_imm,
    input  logic [DATA_W-1:0]       b_imm,
    input  logic                    dest_we,
    input  logic                    pc_increment,
    input  logic                    error_clear,
    output logic [DATA_W-1:0]       result,
    output logic                    result_valid,
    output logic                    sign_flag,
    output logic                    zero_flag,
    output logic                    overflow_flag,
    output logic                    error_flag,
    output logic [NREGS*DATA_W-1:0] registers
);

    logic [DATA_W-1:0] regs [NREGS];

    logic              wb_valid;
    logic              wb_we;
    logic [SEL_W-1:0]  wb_dest;
    logic [DATA_W-1:0] wb_result;
    flags_t            wb_flags;
    logic              err_q;

    logic              hazard_a;
    logic              hazard_b;
    logic              wb_write;
    logic              accept;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] a_opnd;
    logic [DATA_W-1:0] b_opnd;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic              alu_err;
    logic              alu_we;

    assign wb_write = wb_valid && wb_we;
    assign hazard_a = !a_src && wb_write && (a_sel == wb_dest);
    assign hazard_b = !b_src && wb_write && (b_sel == wb_dest);

`ifdef DATAPATH_FORWARD_EN
    assign op_ready = 1'b1;
    assign a_reg    = hazard_a ? wb_result : regs[a_sel];
    assign b_reg    = hazard_b ? wb_result : regs[b_sel];
`else
    assign op_ready = !(op_valid && (hazard_a || hazard_b));
    assign a_reg    = regs[a_sel];
    assign b_reg    = regs[b_sel];
`endif

    assign accept = op_valid && op_ready;
    assign a_opnd = a_src ? a_imm : a_reg;
    assign b_opnd = b_src ? b_imm : b_reg;

    datapath_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (alu_op),
        .a      (a_opnd),
        .b      (b_opnd),
        .result (alu_res),
        .ovf    (alu_ovf),
        .err    (alu_err)
    );

    assign alu_we = dest_we && !alu_err && (alu_op != OP_CMP);

    // WB stage: latch result and flags only for accepted operations
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_dest   <= '0;
            wb_result <= '0;
            wb_flags  <= '0;
            err_q     <= 1'b0;
        end else begin
            wb_valid <= accept;
            err_q    <= (err_q && !error_clear) || (accept && alu_err);
            if (accept) begin
                wb_we         <= alu_we;
                wb_dest       <= dest_sel;
                wb_result     <= alu_res;
                wb_flags.sign <= alu_res[DATA_W-1];
                wb_flags.zero <= (alu_res == '0);
                wb_flags.ovf  <= alu_ovf;
            end
        end
    end

    // Register file: writeback beats the PC increment on register 0
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_write && (wb_dest == SEL_W'(i)))
                    regs[i] <= wb_result;
                else if (i == 0 && pc_increment)
                    regs[i] <= regs[i] + DATA_W'(1);
            end
        end
    end

    // Flattened register view
    always_comb begin
        registers = '0;
        for (int i = 0; i < NREGS; i++)
            registers[i*DATA_W +: DATA_W] = regs[i];
    end

    assign result        = wb_result;
    assign result_valid  = wb_valid;
    assign sign_flag     = wb_flags.sign;
    assign zero_flag     = wb_flags.zero;
    assign overflow_flag = wb_flags.ovf;
    assign error_flag    = err_q;

endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath at DATA_W=16, NREGS=16; works
// with or without DATAPATH_FORWARD_EN defined.
module tb_param_datapath;

    localparam int DW = 16;
    localparam int NR = 16;
`ifdef DATAPATH_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    alu_op;
    logic [3:0]    a_sel, b_sel, dest_sel;
    logic          a_src, b_src;
    logic [DW-1:0] a_imm, b_imm;
    logic          dest_we;
    logic          pc_increment;
    logic          error_clear;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          sign_flag, zero_flag, overflow_flag, error_flag;
    logic [NR*DW-1:0] registers;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    logic [DW-1:0] m_regs [NR];
    bit            p_v, p_we;
    logic [3:0]    p_d;
    logic [DW-1:0] p_val;
    logic [DW-1:0] m_res;
    bit            m_rv, m_sign, m_zero, m_ovf, m_err;

    param_datapath #(.DATA_W(DW), .NREGS(NR)) dut (
        .clock         (clock),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .alu_op        (alu_op),
        .a_sel         (a_sel),
        .b_sel         (b_sel),
        .dest_sel      (dest_sel),
        .a_src         (a_src),
        .b_src         (b_src),
        .a_imm         (a_imm),
        .b_imm         (b_imm),
        .dest_we       (dest_we),
        .pc_increment  (pc_increment),
        .error_clear   (error_clear),
        .result        (result),
        .result_valid  (result_valid),
        .sign_flag     (sign_flag),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .error_flag    (error_flag),
        .registers     (registers)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_alu(
        input logic [3:0] op, input logic [DW-1:0] a, b,
        output logic [DW-1:0] r, output bit ovf, output bit err);
        int sa, sb, s;
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        r = '0; ovf = 0; err = 0;
        case (op)
            4'd0: begin s = sa + sb; r = a + b; ovf = (s > 32767) || (s < -32768); end
            4'd1, 4'd8: begin s = sa - sb; r = a - b; ovf = (s > 32767) || (s < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: if (b >= 16) err = 1; else r = a << b;
            4'd6: if (b >= 16) err = 1; else r = a >> b;
            4'd7: r = b;
            default: err = 1;
        endcase
    endfunction

    // architectural value: includes the write still in flight
    function automatic logic [DW-1:0] view(input logic [3:0] s);
        if (p_v && p_we && p_d == s) return p_val;
        return m_regs[s];
    endfunction

    function automatic bit model_ready();
        bit rd;
        if (FWD || !op_valid || !(p_v && p_we)) return 1'b1;
        rd = (!a_src && a_sel == p_d) || (!b_src && b_sel == p_d);
        return !rd;
    endfunction

    task automatic model_step();
        logic [DW-1:0] av, bv, r;
        bit ovf, err, acc;
        if (reset) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            p_v = 0; p_we = 0; p_d = '0; p_val = '0;
            m_res = '0; m_rv = 0; m_sign = 0; m_zero = 0;
            m_ovf = 0; m_err = 0;
            return;
        end
        r = '0; ovf = 0; err = 0;
        acc = op_valid && model_ready();
        if (acc) begin
            av = a_src ? a_imm : view(a_sel);
            bv = b_src ? b_imm : view(b_sel);
            model_alu(alu_op, av, bv, r, ovf, err);
        end
        m_err = (m_err && !error_clear) || (acc && err);
        if (p_v && p_we) m_regs[p_d] = p_val;
        if (pc_increment && !(p_v && p_we && p_d == 0))
            m_regs[0] = m_regs[0] + 16'd1;
        p_v  = acc;
        m_rv = acc;
        if (acc) begin
            p_we   = dest_we && !err && (alu_op != 4'd8);
            p_d    = dest_sel;
            p_val  = r;
            m_res  = r;
            m_sign = r[DW-1];
            m_zero = (r == '0);
            m_ovf  = ovf;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // every-cycle compare against the model
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            chk("result", result, m_res);
            chk("result_valid", result_valid, m_rv);
            chk("sign", sign_flag, m_sign);
            chk("zero", zero_flag, m_zero);
            chk("ovf", overflow_flag, m_ovf);
            chk("err", error_flag, m_err);
            if (!reset) chk("op_ready", op_ready, model_ready());
            for (int i = 0; i < NR; i++)
                chk($sformatf("reg%0d", i), registers[i*DW +: DW], m_regs[i]);
        end
    end

    function automatic logic [DW-1:0] reg_of(input int i);
        return registers[i*DW +: DW];
    endfunction

    task automatic idle();
        op_valid = 0; pc_increment = 0; error_clear = 0;
        dest_we = 0; a_src = 1; b_src = 1;
    endtask

    task automatic issue(input logic [3:0] op,
                         input logic [3:0] as, input logic asrc,
                         input logic [DW-1:0] ai,
                         input logic [3:0] bs, input logic bsrc,
                         input logic [DW-1:0] bi,
                         input logic [3:0] d, input logic we,
                         output int stalls);
        bit rdy;
        alu_op = op; a_sel = as; a_src = asrc; a_imm = ai;
        b_sel = bs; b_src = bsrc; b_imm = bi;
        dest_sel = d; dest_we = we; op_valid = 1;
        stalls = 0;
        forever begin
            #1 rdy = op_ready;
            @(posedge clock); #2;
            if (rdy) break;
            stalls++;
            if (stalls > 10) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
        op_valid = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a, b, r;
        bit            ovf;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int st;
        vecs[0] = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 1};
        vecs[1] = '{4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 0};
        vecs[2] = '{4'd3, 16'hF000, 16'h000F, 16'hF00F, 0};
        vecs[3] = '{4'd4, 16'hFFFF, 16'h00FF, 16'hFF00, 0};
        vecs[4] = '{4'd5, 16'h0001, 16'h000F, 16'h8000, 0};
        vecs[5] = '{4'd6, 16'h8000, 16'h000F, 16'h0001, 0};
        vecs[6] = '{4'd6, 16'h8000, 16'h0010, 16'h0000, 0};
        vecs[7] = '{4'd7, 16'h1111, 16'hABCD, 16'hABCD, 0};
        vecs[8] = '{4'd8, 16'h0005, 16'h0005, 16'h0000, 0};
        vecs[9] = '{4'd15, 16'h1234, 16'h0001, 16'h0000, 0};

        reset = 1; idle();
        alu_op = 0; a_sel = 0; b_sel = 0; dest_sel = 0;
        a_imm = 0; b_imm = 0;
        cycles(2);
        reset = 0; chk_en = 1;
        #1;
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {sign_flag, zero_flag, overflow_flag, error_flag}, 0);
        chk("rst_ready", op_ready, 1);
        chk("rst_regs", registers, 0);

        // signed overflow on ADD
        issue(4'd0, 4'd0, 1, 16'h7FFF, 4'd0, 1, 16'h0001, 4'd1, 1, st);
        #1;
        chk("add_ovf_result", result, 16'h8000);
        chk("add_ovf_valid", result_valid, 1);
        chk("add_ovf_flags", {sign_flag, zero_flag, overflow_flag}, 3'b101);
        cycles(2);
        chk("add_ovf_r1", reg_of(1), 16'h8000);

        // back-to-back hazard
        issue(4'd7, 4'd0, 1, 0, 4'd0, 1, 16'd5, 4'd3, 1, st);
        cycles(2);
        chk("r3", reg_of(3), 16'd5);
        issue(4'd0, 4'd3, 0, 0, 4'd3, 0, 0, 4'd4, 1, st);
        issue(4'd1, 4'd4, 0, 0, 4'd0, 1, 16'd10, 4'd5, 1, st);
        chk("hazard_stalls", st, FWD ? 0 : 1);
        #1;
        chk("hazard_result", result, 16'd0);
        chk("hazard_zero", zero_flag, 1);
        cycles(2);
        chk("r4", reg_of(4), 16'd10);
        chk("r5", reg_of(5), 16'd0);

        // PC increment vs writeback to r0
        pc_increment = 1;
        issue(4'd7, 4'd0, 1, 0, 4'd0, 1, 16'h0100, 4'd0, 1, st);
        chk("pc_seq1", reg_of(0), 16'h0001);
        cycles(1); chk("pc_seq2", reg_of(0), 16'h0100);
        cycles(1); chk("pc_seq3", reg_of(0), 16'h0101);
        cycles(1); chk("pc_seq4", reg_of(0), 16'h0102);
        pc_increment = 0;
        cycles(1);

        // shift error, sticky flag, clear
        issue(4'd7, 4'd0, 1, 0, 4'd0, 1, 16'h1234, 4'd2, 1, st);
        cycles(1);
        issue(4'd5, 4'd0, 1, 16'h0001, 4'd0, 1, 16'd16, 4'd2, 1, st);
        #1;
        chk("shl_result", result, 16'd0);
        chk("shl_err", error_flag, 1);
        cycles(2);
        chk("shl_dest_kept", reg_of(2), 16'h1234);
        chk("err_sticky", error_flag, 1);
        error_clear = 1;
        cycles(1);
        error_clear = 0;
        chk("err_cleared", error_flag, 0);

        // clear coinciding with a new error keeps the flag
        error_clear = 1;
        issue(4'd9, 4'd0, 1, 0, 4'd0, 1, 0, 4'd6, 1, st);
        error_clear = 0;
        chk("clear_vs_new_err", error_flag, 1);
        error_clear = 1; cycles(1); error_clear = 0;

        // ALU vector table into r8
        foreach (vecs[i]) begin
            issue(vecs[i].op, 4'd0, 1, vecs[i].a, 4'd0, 1, vecs[i].b,
                  4'd8, 1, st);
            #1;
            chk($sformatf("vec%0d_result", i), result, vecs[i].r);
            chk($sformatf("vec%0d_ovf", i), overflow_flag, vecs[i].ovf);
        end
        cycles(2);
        chk("cmp_no_wb_r8", reg_of(8), 16'hABCD);
        error_clear = 1; cycles(1); error_clear = 0;

        // reset with an operation in flight
        issue(4'd7, 4'd0, 1, 0, 4'd0, 1, 16'h0055, 4'd7, 1, st);
        reset = 1; op_valid = 1;
        cycles(1);
        reset = 0; op_valid = 0;
        #1;
        chk("rst_r7", reg_of(7), 16'd0);
        chk("rst_valid", result_valid, 0);
        chk("rst_all_flags",
            {sign_flag, zero_flag, overflow_flag, error_flag}, 0);
        chk("rst_ready2", op_ready, 1);
        cycles(2);
        chk("rst_r7_later", reg_of(7), 16'd0);

        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter DATA_W, default 16: register and ALU word width (legal range 8..64).
REQ-002 Parameter NREGS, default 16: register count, power of two, at least 4; register 0 is the program counter.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port op_valid/op_ready, input/output, 1 each: operation handshake; an operation is accepted when both are 1.
REQ-006 Port alu_op, input, 4: operation code.
REQ-007 Ports a_sel/b_sel/dest_sel, input, log2(NREGS): source and destination register indices.
REQ-008 Ports a_src/b_src, input, 1: 1 selects a_imm/b_imm (DATA_W) instead of the register.
REQ-009 Port dest_we, input, 1: the accepted operation writes back to dest_sel.
REQ-010 Port pc_increment, input, 1: add 1 to register 0 this cycle.
REQ-011 Port error_clear, input, 1: clears the sticky error flag.
REQ-012 Ports result, output, DATA_W, and result_valid, output, 1: writeback-stage value and qualifier.
REQ-013 Ports sign_flag/zero_flag/overflow_flag/error_flag, outputs, 1 each.
REQ-014 Port registers, output, NREGS*DATA_W: flattened register view; register i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-015 Two stages: accept/execute in cycle N; ALU result latched into the WB register; result_valid=1 in cycle N+1; register write at the end of N+1, visible on registers in N+2.
REQ-016 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 PASS_B, 8 CMP (SUB with flags only and no writeback); arithmetic wraps modulo 2^DATA_W.
REQ-017 overflow_flag is the signed overflow of ADD/SUB/CMP and 0 for all other ops; sign_flag is the result MSB; zero_flag is set when the result is all zeros; flags update with the WB register.
REQ-018 SHL/SHR with b >= DATA_W, or an opcode of 9..15, produces result 0, sets error_flag, and suppresses writeback.
REQ-019 error_flag is sticky until error_clear; error_clear together with a new error leaves error_flag at 1.
REQ-020 Register 0 increments by pc_increment every cycle; a writeback to register 0 in the same cycle wins and the increment is dropped.
REQ-021 Reads of register 0 return its current value, before this cycle's increment.
REQ-022 With no accepted operation, result_valid=0 next cycle, and result and flags hold their values.
REQ-023 Hazard: the accepted operation reads (non-immediate) the register the in-flight WB operation writes; handling per REQ-027/028.

Reset
REQ-024 Reset clears all registers, result, every flag and result_valid to 0; op_ready=1 in the first cycle after reset.
REQ-025 Reset during an in-flight operation discards it; no writeback occurs.

Configuration
REQ-026 Macro DATAPATH_FORWARD_EN selects the hazard handling.
REQ-027 When defined: the WB value is forwarded to the hazarding operand; op_ready stays 1; no stall.
REQ-028 When undefined: op_ready=0 combinationally in the hazard cycle; the operation is accepted one cycle later, after writeback.

Structure
REQ-029 Package datapath_pkg holds the opcode constants, the NUM_OPS constant and the flag-bundle struct typedef.
REQ-030 The combinational ALU is a separate sub-module datapath_alu (op, a, b -> result, ovf, err); register file, pipeline and hazard logic stay in param_datapath.

Verification
REQ-031 Bench runs at DATA_W=16, NREGS=16, with and without DATAPATH_FORWARD_EN.
REQ-032 ADD imm 0x7FFF + imm 0x0001 -> result 0x8000, overflow=1, sign=1, zero=0 in cycle N+1.
REQ-033 r3=5, then back-to-back ADD r4=r3+r3 and SUB r5=r4-imm 10 -> r5=0, zero=1; forwarding: no stall; no forwarding: op_ready=0 for exactly one cycle.
REQ-034 pc_increment=1 held for 4 cycles with writeback of 0x0100 to r0 in cycle 2 -> r0 sequence 1, 0x0100, 0x0101, 0x0102.
REQ-035 SHL by 16 -> result 0, error_flag=1, dest unchanged; error_clear -> error_flag=0 next cycle.
REQ-036 Reset asserted while op_valid=1 writing r7 -> r7=0, result_valid=0, all flags 0.
